// File: rtl/moore_seq_generator_pkg.sv
// Shared definitions for the serial sequence generator/detector family:
// FSM state encodings and the len-field width derivation.
package moore_seq_generator_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_SHIFT = 2'b01;
  localparam state_t ST_DONE  = 2'b10;

  // len must be able to express WIDTH itself, hence the extra bit
  function automatic int len_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/moore_seq_generator_if.sv
// Request/stream bundle between a pattern source and the serial generator.
interface moore_seq_generator_if
  import moore_seq_generator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
);
  localparam int LEN_W = len_w(WIDTH);

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] reps;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, len, reps,
    input  x, x_valid, busy, done
  );

  modport slave (
    input  start, pattern, len, reps,
    output x, x_valid, busy, done
  );

endinterface

// File: rtl/moore_seq_generator_piso_shift_reg.sv
// Parallel-in serial-out shift register: parallel load, left shift, MSB out.
module moore_seq_generator_piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift_en) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/moore_seq_generator.sv
// Moore serial pattern generator: captures up to WIDTH bits on start and
// emits them MSB-first, reps+1 passes back-to-back, then pulses done.
module moore_seq_generator
  import moore_seq_generator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  moore_seq_generator_if.slave  bus
);

  localparam int LEN_W = len_w(WIDTH);
  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bit_cnt;
  logic [REP_W-1:0] pass_cnt;
  logic [WIDTH-1:0] pat_q;

  logic [LEN_W-1:0] len_c;
  logic [WIDTH-1:0] pat_aligned;
  logic [WIDTH-1:0] load_data;
  logic             accept;
  logic             last_bit;
  logic             reload;
  logic             sr_load;
  logic             sr_shift;
  logic             sr_msb;

  // Left-align the active field so the shifter always emits from its MSB;
  // bits above len fall off the top and are ignored.
  always_comb begin
    len_c       = (bus.len > WIDTH_L) ? WIDTH_L : bus.len;
    pat_aligned = bus.pattern << (WIDTH_L - len_c);
    accept      = (state == ST_IDLE) && bus.start && (bus.len != '0);
    last_bit    = (bit_cnt == '0);
    reload      = (state == ST_SHIFT) && last_bit && (pass_cnt != '0);
    sr_load     = accept || reload;
    sr_shift    = (state == ST_SHIFT) && !last_bit;
    load_data   = accept ? pat_aligned : pat_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      bit_cnt  <= '0;
      pass_cnt <= '0;
      pat_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_SHIFT;
            pat_q    <= pat_aligned;
            len_q    <= len_c;
            bit_cnt  <= len_c - LEN_W'(1);
            pass_cnt <= bus.reps;
          end
        end
        ST_SHIFT: begin
          if (!last_bit) begin
            bit_cnt <= bit_cnt - LEN_W'(1);
          end else if (pass_cnt != '0) begin
            // next pass starts on the very next cycle, no gap
            bit_cnt  <= len_q - LEN_W'(1);
            pass_cnt <= pass_cnt - REP_W'(1);
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  moore_seq_generator_piso_shift_reg #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (sr_load),
    .shift_en (sr_shift),
    .din      (load_data),
    .msb      (sr_msb)
  );

  assign bus.x       = (state == ST_SHIFT) && sr_msb;
  assign bus.x_valid = (state == ST_SHIFT);
  assign bus.busy    = (state == ST_SHIFT);
  assign bus.done    = (state == ST_DONE);

endmodule
